// File: rtl/mult_sequencer.sv
// Iterative radix-2 shift-add multiplier owning the HI/LO pair.
// One WIDTH-bit adder; sign handled by magnitude prep and final negate.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIXUP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_mc;
  logic [WIDTH-1:0]   r_mb;
  logic               r_sgn;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_wr_ok;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !kill) begin
          w_next   = S_PREP;
          w_accept = 1'b1;
        end
      end
      S_PREP:  w_next = kill ? S_IDLE : S_RUN;
      S_RUN: begin
        if (kill)               w_next = S_IDLE;
        else if (r_cnt == LAST) w_next = S_FIXUP;
      end
      S_FIXUP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // carry out of the upper-half add becomes the shifted-in MSB
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mc};
  assign w_res   = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
  assign w_wr_ok = (r_state == S_IDLE) && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mc   <= '0;
      r_mb   <= '0;
      r_sgn  <= 1'b0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mc  <= op_a;
        r_mb  <= op_b;
        r_sgn <= is_signed;
      end else if (w_wr_ok) begin
        if (mthi) r_hi <= wr_data;
        if (mtlo) r_lo <= wr_data;
      end
      if (r_state == S_PREP) begin
        if (r_sgn && r_mc[WIDTH-1]) r_mc <= -r_mc;
        if (r_sgn && r_mb[WIDTH-1]) r_mb <= -r_mb;
        r_neg <= r_sgn & (r_mc[WIDTH-1] ^ r_mb[WIDTH-1]);
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_RUN) begin
        if (r_mb[0]) r_acc <= {w_sum, r_acc[WIDTH-1:1]};
        else         r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
        r_mb  <= r_mb >> 1;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_FIXUP && !kill) begin
        {r_hi, r_lo} <= w_res;
        r_done       <= 1'b1;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: table vectors, corner
// sequences and random multiplies against an arithmetic model.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_signed, mthi, mtlo, kill;
  logic [31:0] op_a, op_b, wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo),
    .wr_data(wr_data), .kill(kill), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(bit s, logic [31:0] a,
                                           logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit s, logic [31:0] a, logic [31:0] b);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit bz);
    lat = 0; bz = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) bz = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic write_hl(bit h, bit l, logic [31:0] d);
    mthi = h; mtlo = l; wr_data = d;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
  endtask

  task automatic mult_chk(string nm, bit s, logic [31:0] a,
                          logic [31:0] b, logic [63:0] exp, bit gap);
    int lat;
    bit bz;
    issue(s, a, b);
    wait_done(lat, bz);
    chk({nm, "_lat"}, 64'(lat), 64'd34);
    chk({nm, "_busy"}, {63'b0, bz & ~busy}, 64'd1);
    chk({nm, "_hilo"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
    if (gap) begin
      tick();
      chk({nm, "_pulse"}, {62'b0, done, busy}, 64'd0);
    end
  endtask

  vec_t tbl[7];
  int   lat;
  bit   bz;

  initial begin
    tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tbl[1] = '{1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
    tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tbl[3] = '{1'b1, 32'd7,        32'd0,        64'h0};
    tbl[4] = '{1'b1, 32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_FFFFFFFF};
    tbl[5] = '{1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
    tbl[6] = '{1'b0, 32'h80000000, 32'd2,        64'h00000001_00000000};

    rst_n = 1'b0; start = 0; is_signed = 0; mthi = 0; mtlo = 0;
    kill = 0; op_a = 0; op_b = 0; wr_data = 0;
    m_hi = 0; m_lo = 0;
    repeat (2) tick();
    chk("reset_out", {busy, done, hi, lo}, 66'(0));
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      write_hl(1'b1, 1'b1, 32'h5A5A0000 + i);
      mult_chk($sformatf("tbl%0d", i), tbl[i].s, tbl[i].a, tbl[i].b,
               tbl[i].p, 1'b1);
    end

    // back-to-back start in the done cycle
    mult_chk("b2b_a", 1'b1, 32'hFFFFFFFD, 32'd5,
             64'hFFFFFFFF_FFFFFFF1, 1'b0);
    mult_chk("b2b_b", 1'b1, 32'h80000000, 32'h80000000,
             64'h40000000_00000000, 1'b1);

    // zero product after preset; then -1 x 1
    write_hl(1'b1, 1'b1, 32'h12345678);
    write_hl(1'b0, 1'b1, 32'h9ABCDEF0);
    chk("preset", {hi, lo}, 64'h12345678_9ABCDEF0);
    mult_chk("zero", 1'b1, 32'd7, 32'd0, 64'h0, 1'b1);
    mult_chk("neg1", 1'b1, 32'hFFFFFFFF, 32'd1, {64{1'b1}}, 1'b1);

    // idle mthi, then mtlo + start ignored mid RUN
    write_hl(1'b1, 1'b0, 32'hAAAA0000);
    chk("mthi", {hi, lo}, {32'hAAAA0000, m_lo});
    issue(1'b0, 32'd1000, 32'd3000);
    repeat (5) tick();
    mtlo = 1'b1; wr_data = 32'hDEADBEEF;
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    tick();
    mtlo = 1'b0; start = 1'b0;
    chk("busy_hold", {hi, lo}, {m_hi, m_lo});
    wait_done(lat, bz);
    chk("ign_lat", 64'(lat), 64'd28);
    chk("ign_res", {hi, lo}, 64'd3000000);
    m_hi = 0; m_lo = 32'd3000000;
    tick();
    chk("ign_noq", {62'b0, busy, done}, 64'd0);

    // start with mthi in idle: start wins
    mthi = 1'b1; wr_data = 32'h77777777;
    mult_chk("st_wins", 1'b0, 32'd5, 32'd5, 64'd25, 1'b1);
    mthi = 1'b0;

    // kill in idle blocks start
    kill = 1'b1;
    issue(1'b0, 32'd2, 32'd2);
    kill = 1'b0;
    chk("kill_idle", {62'b0, busy, done}, 64'd0);

    // kill at RUN iteration 10
    write_hl(1'b1, 1'b1, 32'h11);
    write_hl(1'b0, 1'b1, 32'h22);
    issue(1'b0, 32'd6, 32'd7);
    repeat (10) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", {62'b0, busy, done}, 64'd0);
    repeat (40) begin
      if (done) chk("kill_nodone", 64'(done), 64'd0);
      tick();
    end
    chk("kill_hilo", {hi, lo}, 64'h11_00000022);
    mult_chk("after_kill", 1'b0, 32'd6, 32'd7, 64'd42, 1'b1);

    // kill in FIXUP suppresses the write
    issue(1'b0, 32'd3, 32'd3);
    repeat (33) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_fix", {busy, done, hi, lo}, {2'b00, m_hi, m_lo});

    // asynchronous reset mid RUN
    write_hl(1'b1, 1'b0, 32'hCAFE);
    issue(1'b1, 32'hFFFF0000, 32'h1234);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, done, hi, lo}, 66'(0));
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mult_chk("post_rst", 1'b0, 32'd3, 32'd4, 64'd12, 1'b1);

    // random operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      bit s;
      int sel;
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1) == 1;
      if (sel == 0) a = 32'h80000000;
      if (sel == 1) b = 32'd0;
      if (sel < 3) begin
        write_hl(sel[0], !sel[0] || (sel == 2), $urandom);
        chk($sformatf("rnd_wr%0d", n), {hi, lo}, {m_hi, m_lo});
      end
      mult_chk($sformatf("rnd%0d", n), s, a, b, ref_prod(s, a, b),
               $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
